// File: rtl/config_saver_if.sv
// SRAM path between the core and the SRAM pins, plus the core's idle flag.
// master: the core/pin side; slave: config_saver sitting in the path.
interface config_saver_if;
    logic [20:0] sram_addr_in;
    logic [7:0]  sram_data_in;
    logic        sram_we_n_in;
    logic        bus_idle;
    logic [20:0] sram_addr_out;
    logic [7:0]  sram_data_out;
    logic        sram_we_n_out;

    modport master (
        output sram_addr_in, sram_data_in, sram_we_n_in, bus_idle,
        input  sram_addr_out, sram_data_out, sram_we_n_out
    );

    modport slave (
        input  sram_addr_in, sram_data_in, sram_we_n_in, bus_idle,
        output sram_addr_out, sram_data_out, sram_we_n_out
    );
endinterface

// File: rtl/config_saver.sv
// config_saver: persists the video configuration byte (VGA enable, scanlines
// enable) to a fixed SRAM location. Once the settings have been stable and
// different from the last saved value for SETTLE cycles (or a save is
// requested), it waits for an idle bus slot, takes over the SRAM path for
// WE_CYCLES+2 cycles to write the byte, then hands the bus back.
module config_saver #(
    parameter logic [20:0] CFG_ADDR  = 21'h008FD5,
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vga_on,
    input  logic          scanlines_on,
    input  logic          save_req,
    config_saver_if.slave sram,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT_BUS,
        S_SETUP,
        S_WRITE,
        S_HOLD
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0] WE_LAST     = 4'(WE_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] cfg;
    logic [7:0] saved, saved_n;
    logic [7:0] latched, latched_n;
    logic [7:0] prev_cfg;
    logic [7:0] settle_cnt, settle_n;
    logic       pend, pend_n;
    logic [3:0] we_cnt, we_cnt_n;
    logic       busy_n, done_n;
    logic       cfg_changed, cfg_dirty;
    logic       takeover;

    assign cfg         = {6'b0, scanlines_on, vga_on};
    assign cfg_changed = (cfg != prev_cfg);
    assign cfg_dirty   = (cfg != saved);
    assign takeover    = (state == S_SETUP) || (state == S_WRITE) || (state == S_HOLD);

    // State and datapath registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            saved      <= '0;
            latched    <= '0;
            prev_cfg   <= '0;
            settle_cnt <= '0;
            pend       <= 1'b0;
            we_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            saved      <= saved_n;
            latched    <= latched_n;
            prev_cfg   <= cfg;
            settle_cnt <= settle_n;
            pend       <= pend_n;
            we_cnt     <= we_cnt_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state logic: settle tracking, save scheduling and write sequencing.
    always_comb begin
        state_n   = state;
        saved_n   = saved;
        latched_n = latched;
        settle_n  = settle_cnt;
        pend_n    = pend | save_req;
        we_cnt_n  = we_cnt;
        done_n    = 1'b0;

        case (state)
            S_INIT: begin
                saved_n  = cfg;
                settle_n = '0;
                state_n  = S_IDLE;
            end
            S_IDLE: begin
                if (cfg_changed || !cfg_dirty) begin
                    settle_n = '0;
                end else if (settle_cnt != '1) begin
                    settle_n = settle_cnt + 8'd1;
                end
                // A value that changed this very cycle is not settled yet,
                // even if the counter happens to sit on the threshold.
                if (pend || (cfg_dirty && !cfg_changed && settle_cnt == SETTLE_LAST)) begin
                    latched_n = cfg;
                    pend_n    = 1'b0;
                    state_n   = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                settle_n = '0;
                if (sram.bus_idle) begin
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                settle_n = '0;
                we_cnt_n = WE_LAST;
                state_n  = S_WRITE;
            end
            S_WRITE: begin
                settle_n = '0;
                if (we_cnt == '0) begin
                    state_n = S_HOLD;
                end else begin
                    we_cnt_n = we_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                saved_n  = latched;
                settle_n = '0;
                done_n   = 1'b1;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_INIT;
            end
        endcase

        case (state_n)
            S_WAIT_BUS, S_SETUP, S_WRITE, S_HOLD: busy_n = 1'b1;
            S_IDLE:                               busy_n = pend_n || (cfg != saved_n);
            default:                              busy_n = 1'b0;
        endcase
    end

    // SRAM path mux: config write during takeover, core pass-through otherwise.
    always_comb begin
        sram.sram_addr_out = sram.sram_addr_in;
        sram.sram_data_out = sram.sram_data_in;
        sram.sram_we_n_out = sram.sram_we_n_in;
        if (takeover) begin
            sram.sram_addr_out = CFG_ADDR;
            sram.sram_data_out = latched;
            sram.sram_we_n_out = (state != S_WRITE);
        end
    end
endmodule
